// File: rtl/scan_pkg.sv
// Shared types and constants for the raster scan counter.
package scan_pkg;

    typedef enum logic {
        AXIS_IDLE = 1'b0,
        AXIS_RUN  = 1'b1
    } axis_state_e;

    localparam int unsigned DEF_WIDTH_C  = 640;
    localparam int unsigned DEF_HEIGHT_C = 480;
    localparam int unsigned MIN_WIDTH    = 2;
    localparam int unsigned MIN_HEIGHT   = 1;

endpackage

// File: rtl/scan_axis_counter.sv
// One scan axis: start/advance counter with a latched length, end pulse and near-end decode.
module scan_axis_counter
    import scan_pkg::*;
#(
    parameter int unsigned W                  = 10,
    parameter int unsigned NEAR_OFF           = 1,
    parameter int unsigned MIN_LEN            = 1,
    parameter int unsigned DEF_LEN            = 1,
    // 1: dropping enable while running stops the axis (column); 0: enable is a strobe (row).
    parameter bit          STOP_ON_IDLE       = 1'b0,
    parameter bit          LATCH_IN_IDLE_ONLY = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         enable,
    input  logic [W-1:0] cfg_len,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         at_near,
    output logic         done
);

    localparam logic [W-1:0] NEAR_W = W'(NEAR_OFF);
    localparam logic [W-1:0] MIN_W  = W'(MIN_LEN);
    localparam logic [W-1:0] DEF_W  = W'(DEF_LEN);
    localparam logic [W-1:0] ONE_W  = W'(1);

    axis_state_e  state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] len_q, len_d;
    logic         done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (start && enable) begin
            if (!LATCH_IN_IDLE_ONLY || (state_q == AXIS_IDLE)) begin
                len_d = (cfg_len < MIN_W) ? MIN_W : cfg_len;
            end
            cnt_d   = '0;
            state_d = AXIS_RUN;
        end else if (state_q == AXIS_RUN) begin
            if (enable) begin
                // Last position: stop and hold rather than wrap.
                if (cnt_q == len_q - ONE_W) begin
                    state_d = AXIS_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end else if (STOP_ON_IDLE) begin
                state_d = AXIS_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= AXIS_IDLE;
            cnt_q   <= '0;
            len_q   <= DEF_W;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign cnt     = cnt_q;
    assign active  = (state_q == AXIS_RUN);
    assign at_near = (cnt_q == len_q - NEAR_W);
    assign done    = done_q;

endmodule

// File: rtl/scan_counter_xy.sv
// Raster scan counter: independent column and row axes built from one generic axis counter.
module scan_counter_xy
    import scan_pkg::*;
#(
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned DEF_WIDTH  = DEF_WIDTH_C,
    parameter int unsigned DEF_HEIGHT = DEF_HEIGHT_C
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] cfg_width,
    input  logic [Y_W-1:0] cfg_height,
    input  logic           start_x,
    input  logic           enable_x,
    input  logic           start_y,
    input  logic           enable_y,
    output logic           near_end_x,
    output logic           near_end_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           x_active,
    output logic           row_done,
    output logic           frame_done
);

    logic x_at_near;
    logic y_at_near;
    logic y_active;

    scan_axis_counter #(
        .W                  (X_W),
        .NEAR_OFF           (2),
        .MIN_LEN            (MIN_WIDTH),
        .DEF_LEN            (DEF_WIDTH),
        .STOP_ON_IDLE       (1'b1),
        .LATCH_IN_IDLE_ONLY (1'b1)
    ) u_x_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_x),
        .enable  (enable_x),
        .cfg_len (cfg_width),
        .cnt     (x),
        .active  (x_active),
        .at_near (x_at_near),
        .done    (row_done)
    );

    scan_axis_counter #(
        .W                  (Y_W),
        .NEAR_OFF           (1),
        .MIN_LEN            (MIN_HEIGHT),
        .DEF_LEN            (DEF_HEIGHT),
        .STOP_ON_IDLE       (1'b0),
        .LATCH_IN_IDLE_ONLY (1'b0)
    ) u_y_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_y),
        .enable  (enable_y),
        .cfg_len (cfg_height),
        .cnt     (y),
        .active  (y_active),
        .at_near (y_at_near),
        .done    (frame_done)
    );

    assign near_end_x = x_active & x_at_near;
    assign near_end_y = y_active & y_at_near;

endmodule

// File: doc/scan_counter_xy.md
SCAN_COUNTER_XY -- requirements
Module: scan_counter_xy

Interface
REQ-001 SHALL have parameter X_W, default 10, width of column counter and cfg_width.
REQ-002 SHALL have parameter Y_W, default 10, width of row counter and cfg_height.
REQ-003 SHALL have parameters DEF_WIDTH, default 640, and DEF_HEIGHT, default 480, which are the config values after reset.
REQ-004 Ports:
  clk  in  1  single clock, all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  cfg_width  in  X_W  columns per row, sampled per REQ-008
  cfg_height  in  Y_W  rows per frame, sampled per REQ-013
  start_x  in  1  start or restart a row; effective only with enable_x=1
  enable_x  in  1  column counter enable
  start_y  in  1  start a frame; effective only with enable_y=1
  enable_y  in  1  row advance strobe, one cycle per row
  near_end_x  out  1  column counter at width-2
  near_end_y  out  1  row counter at height-1
  x  out  X_W  current column
  y  out  Y_W  current row
  x_active  out  1  x holds a live column position
  row_done  out  1  one-cycle pulse after a row ends without restart
  frame_done  out  1  one-cycle pulse when the last row is advanced past

Function
REQ-005 SHALL register all outputs except near_end_x and near_end_y, which are combinational decodes of registered state.
REQ-006 Column FSM SHALL have two states, X_IDLE and X_RUN. x_active is 1 iff the state is X_RUN.
REQ-007 start_x=1 with enable_x=1 SHALL give state X_RUN and x=0 on the next cycle, from either state (restart mid-row allowed, no gap).
REQ-008 cfg_width SHALL be latched into w_reg only on an effective start_x while in X_IDLE. Values below 2 SHALL be clamped to 2.
REQ-009 In X_RUN with enable_x=1 and no start_x, x SHALL increment by 1 per cycle until x=w_reg-1.
REQ-010 At x=w_reg-1 with no start_x, the FSM SHALL go to X_IDLE next cycle, x SHALL hold, and row_done SHALL pulse for 1 cycle.
REQ-011 near_end_x SHALL equal (X_RUN && x==w_reg-2). A start_x registered in response lands on x=w_reg-1, so the next row begins with zero bubble.
REQ-012 enable_x=0 in X_RUN SHALL give X_IDLE next cycle with x held and no row_done.
REQ-013 Row FSM SHALL have states Y_IDLE and Y_RUN. start_y with enable_y SHALL give y=0 and Y_RUN, and latch cfg_height into h_reg, clamped to a minimum of 1.
REQ-014 In Y_RUN, enable_y=1 without start_y SHALL increment y. If y==h_reg-1, the FSM SHALL instead go to Y_IDLE, hold y, and pulse frame_done.
REQ-015 near_end_y SHALL equal (Y_RUN && y==h_reg-1).
REQ-016 enable_y in Y_IDLE without start_y SHALL be ignored.
REQ-017 Counters SHALL never wrap. Arithmetic SHALL be unsigned, at X_W and Y_W widths.
REQ-018 Column and row logic SHALL be independent. Simultaneous events on both axes SHALL each follow their own rules in the same cycle.

Reset
REQ-019 With rst_n=0 at a clock edge, the following SHALL result, regardless of other inputs, including mid-row and mid-frame:
  - states X_IDLE and Y_IDLE
  - x=0, y=0
  - x_active=0, row_done=0, frame_done=0
  - w_reg=DEF_WIDTH, h_reg=DEF_HEIGHT
REQ-020 near_end_x and near_end_y SHALL be 0 in the cycle after reset.

Structure
REQ-021 Package scan_pkg SHALL hold:
  - axis state enum (IDLE, RUN)
  - default width and height constants
  - minimum width constant (2)
REQ-022 One generic sub-module, scan_axis_counter, SHALL be parameterised by width and near-end offset, and instantiated once per axis.

Verification
REQ-023 Reset, then start_x+enable_x with cfg_width=5 and enable_x held -> x=0,1,2,3,4; near_end_x only at x=3; row_done 1 cycle after x=4.
REQ-024 width=5, start_x asserted the cycle after near_end_x -> x sequence 3,4,0,1 with no row_done and x_active continuously 1.
REQ-025 cfg_width=1 -> counts 0,1 (clamped to 2); near_end_x at x=0.
REQ-026 start_y with cfg_height=3, then three enable_y strobes -> y=0,1,2; near_end_y at y=2; frame_done on the third strobe; y holds 2.
REQ-027 rst_n=0 mid-row at x=7 with enable_x=1 -> next cycle x=0, x_active=0, near_end_x=0, w_reg=640.
REQ-028 start_x at x=2 with width=8 -> x=0 next cycle, no row_done; cfg_width change ignored while in X_RUN.
